row_bound_finder_512bit: RTL and testbench
==========================================

Name: row_bound_finder_512bit

Overview:
Upstream stage of mask_gen_512bit. It scans one 512-bit pixel row and counts the zero pixels before the first set pixel. Left mode counts from bit 511 downward; right mode counts from bit 0 upward. The count is produced as a 9-bit bound index, resolved MSB-first by a 9-step binary search. The index drives mask_gen_512bit.i_bound_index directly. The block uses the same i_trig/o_done handshake as mask_gen_512bit.

Parameters:
IDX_W, 9, index width; row width ROW_W = 1<<IDX_W = 512; scan length = IDX_W steps

Ports:
i_clk  in  1  clock, single clock domain, rising edge
i_rstn  in  1  asynchronous active-low reset
i_trig  in  1  request; held high until o_done is seen, then dropped
i_left_or_right  in  1  0 = count leading zeros from bit 511; 1 = count trailing zeros from bit 0
i_row  in  512  pixel row; sampled only when a request is accepted
o_done  out  1  result valid; o_done = (state==DONE) & i_trig
o_bound_index  out  9  zero-run length, saturating at 511
o_empty  out  1  row was all zero

Behaviour:
- Reset (async, i_rstn=0):
  - state = IDLE, step counter = 0, working vector = 0.
  - o_bound_index = 0, o_empty = 0, o_done = 0.
  - Applies at any time, including mid-scan; the scan in progress is abandoned.
- States: IDLE, SCAN, DONE. A 4-bit step counter k runs 0..8 inside SCAN.
- IDLE:
  - o_bound_index and o_empty keep their previous values (not cleared).
  - On a clock edge with i_trig=1:
    - working vector w <= i_row if i_left_or_right=0, else bit-reversed i_row.
    - o_empty <= ~|i_row.
    - index register <= 0, k <= 0, state -> SCAN.
  - i_row and i_left_or_right are ignored at all other times.
- SCAN step k, with chunk size c = 256>>k:
  - If w[511 -: c] == 0: index bit (8-k) <= 1 and w <= w << c.
  - Otherwise: index bit (8-k) <= 0 and w is unchanged.
  - k=8 (c=1) is the last step; state -> DONE on the same edge.
- Latency: exactly 10 rising edges from the edge that accepts i_trig to state == DONE (1 accept edge + 9 SCAN edges). This matches mask_gen_512bit.
- o_bound_index:
  - Updates only on the final SCAN edge.
  - It is never visible as a partial result.
  - It stays stable from DONE until the next accepted request.
- DONE:
  - Stays in DONE while i_trig=1.
  - Returns to IDLE on the first edge with i_trig=0.
  - o_done drops combinationally in the same cycle i_trig falls.
- i_trig dropped during SCAN: the scan still completes. DONE lasts one cycle, then IDLE. No o_done pulse occurs, but the result is still written.
- All-zero row: every step sets its bit, so o_bound_index = 511 (true count 512 saturates) and o_empty = 1.
- Bit 511 set (left mode) or bit 0 set (right mode): index = 0.
- Arithmetic: shifts only; no adders. The index is unsigned 9-bit.

Decomposition:
- Shared package cdf_pkg:
  - IDX_W, ROW_W.
  - Handshake state localparams IDLE/SCAN/DONE.
  - Chunk-size function c(k) = ROW_W>>(k+1).
- One natural sub-module: bit_reverse_512, a combinational reversal used for right mode. It lets one left-scan datapath serve both directions.

Test Plan:
1. Left mode, i_row = 512'h1 (only bit 0) -> after 10 edges o_done=1, o_bound_index=511, o_empty=0.
2. Left mode, only bit 511 set -> o_bound_index=0. Left mode, only bit 200 set -> o_bound_index=311.
3. Right mode, bits 300 and 5 set -> o_bound_index=5. Right mode, only bit 511 set -> o_bound_index=511, o_empty=0.
4. Left mode, i_row = 0 -> o_bound_index=511, o_empty=1.
5. Handshake:
   - Hold i_trig 20 cycles -> o_done stays 1 and the index is stable.
   - Drop i_trig -> o_done=0 in the same cycle and IDLE next edge; the index is held.
   - Change i_row during SCAN -> no effect on the result.
6. Reset and aborted request:
   - Assert i_rstn=0 at SCAN k=4 -> immediate o_bound_index=0, o_done=0, IDLE.
   - Drop i_trig at k=2 -> no o_done pulse, IDLE after DONE, o_bound_index = scan result.
   - End-to-end: chain to mask_gen_512bit in left mode with bit 200 set -> mask has bits [511:201] set.

Source files
------------

// File: rtl/cdf_pkg.sv
// Shared widths, handshake states and chunk-size helper for the row bound finder.
package cdf_pkg;

    localparam int IDX_W = 9;
    localparam int ROW_W = 1 << IDX_W;
    localparam int K_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits examined at binary-search step k: 256, 128, ... 1.
    function automatic logic [IDX_W:0] chunk(input logic [K_W-1:0] k);
        return (IDX_W + 1)'(ROW_W >> (int'(k) + 1));
    endfunction

endpackage

// File: rtl/bit_reverse_512.sv
// Combinational bit reversal so right-mode rows can reuse the MSB-first scan.
module bit_reverse_512
    import cdf_pkg::*;
(
    input  logic [ROW_W-1:0] i_row,
    output logic [ROW_W-1:0] o_row
);

    always_comb begin
        o_row = '0;
        for (int i = 0; i < ROW_W; i++) begin
            o_row[i] = i_row[ROW_W-1-i];
        end
    end

endmodule

// File: rtl/row_bound_finder_512bit.sv
// Zero-run length before the first set pixel of a 512-bit row, found by a 9-step MSB-first binary search.
// state | meaning:  IDLE | wait for i_trig;  SCAN | one index bit per edge, k=0..8;  DONE | result held until i_trig drops
module row_bound_finder_512bit
    import cdf_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_trig,
    input  logic             i_left_or_right,
    input  logic [ROW_W-1:0] i_row,
    output logic             o_done,
    output logic [IDX_W-1:0] o_bound_index,
    output logic             o_empty
);

    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [ROW_W-1:0] w_q, w_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] bound_q, bound_d;
    logic             empty_q, empty_d;

    logic [ROW_W-1:0] row_rev;
    logic [ROW_W-1:0] hi_mask;
    logic [IDX_W:0]   c;
    logic             chunk_zero;

    bit_reverse_512 u_bit_reverse (
        .i_row (i_row),
        .o_row (row_rev)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        w_d        = w_q;
        idx_d      = idx_q;
        bound_d    = bound_q;
        empty_d    = empty_q;
        c          = chunk(k_q);
        hi_mask    = ~({ROW_W{1'b1}} >> c);
        chunk_zero = ~|(w_q & hi_mask);

        case (state_q)
            IDLE: begin
                if (i_trig) begin
                    w_d     = i_left_or_right ? row_rev : i_row;
                    empty_d = ~|i_row;
                    idx_d   = '0;
                    k_d     = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                idx_d[K_W'(IDX_W-1) - k_q] = chunk_zero;
                if (chunk_zero) begin
                    w_d = w_q << c;
                end
                // Publish only the complete index so no partial result is ever visible.
                if (k_q == K_W'(IDX_W-1)) begin
                    bound_d = idx_d;
                    state_d = DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            DONE: begin
                if (!i_trig) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            k_q     <= '0;
            w_q     <= '0;
            idx_q   <= '0;
            bound_q <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
            bound_q <= bound_d;
            empty_q <= empty_d;
        end
    end

    assign o_done        = (state_q == DONE) & i_trig;
    assign o_bound_index = bound_q;
    assign o_empty       = empty_q;

endmodule

// File: tb/tb_row_bound_finder_512bit.sv
// Directed and randomized requests checked against a pixel-counting reference model.
module tb_row_bound_finder_512bit;

    logic         i_clk = 1'b0;
    logic         i_rstn = 1'b0;
    logic         i_trig = 1'b0;
    logic         i_left_or_right = 1'b0;
    logic [511:0] i_row = '0;
    logic         o_done;
    logic [8:0]   o_bound_index;
    logic         o_empty;

    int checks = 0;
    int failures = 0;

    row_bound_finder_512bit dut (
        .i_clk           (i_clk),
        .i_rstn          (i_rstn),
        .i_trig          (i_trig),
        .i_left_or_right (i_left_or_right),
        .i_row           (i_row),
        .o_done          (o_done),
        .o_bound_index   (o_bound_index),
        .o_empty         (o_empty)
    );

    always #5 i_clk = ~i_clk;

    `define CHK(TAG, OBS, EXP) \
        begin \
            checks++; \
            assert ((OBS) === (EXP)) else begin \
                failures++; \
                $error("FAIL %s observed=%0d expected=%0d", TAG, OBS, EXP); \
            end \
        end

    // Count zero pixels walking from the scan origin; the 9-bit result saturates.
    function automatic int model_idx(input logic [511:0] row, input logic lr);
        int n = 0;
        for (int i = 0; i < 512; i++) begin
            if (lr ? row[i] : row[511-i]) break;
            n++;
        end
        return (n > 511) ? 511 : n;
    endfunction

    function automatic logic [511:0] rand_row();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Full request: accept, check 10-edge latency, result, then release i_trig.
    task automatic run_req(input logic [511:0] row, input logic lr,
                           input logic [511:0] scramble, input string tag);
        int lat;
        int exp_idx;
        exp_idx = model_idx(row, lr);
        @(negedge i_clk);
        i_row = row;
        i_left_or_right = lr;
        i_trig = 1'b1;
        lat = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge i_clk);
            if (n == 1) begin
                i_row = scramble;
                i_left_or_right = ~lr;
            end
            if (o_done) begin
                lat = n;
                break;
            end
        end
        `CHK({tag, "_latency"}, lat, 10)
        `CHK({tag, "_index"}, int'(o_bound_index), exp_idx)
        `CHK({tag, "_empty"}, o_empty, ~|row)
        i_trig = 1'b0;
        #1;
        `CHK({tag, "_done_drop"}, o_done, 1'b0)
        @(negedge i_clk);
        `CHK({tag, "_index_held"}, int'(o_bound_index), exp_idx)
    endtask

    logic [511:0] r;
    logic [511:0] one;
    int           exp_i;
    int           hold_idx;
    bit           pulse;
    logic         lr;

    initial begin
        one = 512'h1;
        #12;
        `CHK("reset_done", o_done, 1'b0)
        `CHK("reset_index", int'(o_bound_index), 0)
        `CHK("reset_empty", o_empty, 1'b0)
        i_rstn = 1'b1;

        run_req(one, 1'b0, '1, "left_bit0");
        run_req(one << 511, 1'b0, '0, "left_bit511");
        run_req(one << 200, 1'b0, '1, "left_bit200");
        run_req((one << 300) | (one << 5), 1'b1, '0, "right_300_5");
        run_req(one << 511, 1'b1, '1, "right_bit511");
        run_req(one, 1'b1, '0, "right_bit0");
        run_req('0, 1'b0, '1, "left_zero");
        run_req('0, 1'b1, one, "right_zero");

        // Long hold: o_done stays high and the index stays put.
        @(negedge i_clk);
        i_row = one << 100;
        i_left_or_right = 1'b0;
        i_trig = 1'b1;
        repeat (10) @(negedge i_clk);
        for (int n = 0; n < 20; n++) begin
            checks++;
            assert (o_done === 1'b1 && o_bound_index === 9'd411) else begin
                failures++;
                $error("FAIL hold_cycle%0d observed done=%0b idx=%0d expected done=1 idx=411",
                       n, o_done, o_bound_index);
            end
            @(negedge i_clk);
        end
        i_trig = 1'b0;
        #1;
        `CHK("hold_drop", o_done, 1'b0)
        @(negedge i_clk);

        // Reset mid-scan at k=4.
        i_row = one << 3;
        i_trig = 1'b1;
        repeat (5) @(negedge i_clk);
        i_trig = 1'b0;
        i_rstn = 1'b0;
        #1;
        `CHK("midscan_rst_index", int'(o_bound_index), 0)
        `CHK("midscan_rst_done", o_done, 1'b0)
        `CHK("midscan_rst_empty", o_empty, 1'b0)
        @(negedge i_clk);
        i_rstn = 1'b1;
        run_req(one << 17, 1'b1, '0, "after_rst");

        // Trigger dropped at k=2: no o_done pulse, result still written.
        i_row = one << 50;
        i_left_or_right = 1'b0;
        i_trig = 1'b1;
        repeat (3) @(negedge i_clk);
        i_trig = 1'b0;
        pulse = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(negedge i_clk);
            if (o_done) pulse = 1'b1;
        end
        `CHK("abort_no_pulse", pulse, 1'b0)
        `CHK("abort_index", int'(o_bound_index), 461)
        run_req(one << 511, 1'b0, '0, "after_abort");

        // Randomized rows with a varied zero run on the scanned side.
        for (int t = 0; t < 24; t++) begin
            r = rand_row();
            lr = 1'($urandom_range(0, 1));
            if (lr) r = r << $urandom_range(0, 511);
            else    r = r >> $urandom_range(0, 511);
            if (t % 11 == 10) r = '0;
            run_req(r, lr, rand_row(), $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
